// File: rtl/uart_byte_tx_if.sv
// Request and serial-line signals between the command/response logic and uart_byte_tx.
// master = requester (send_en, data_byte), slave = transmitter (uart_tx, tx_busy, tx_done).
interface uart_byte_tx_if;
  logic       send_en;
  logic [7:0] data_byte;
  logic       uart_tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output send_en,
    output data_byte,
    input  uart_tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  send_en,
    input  data_byte,
    output uart_tx,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_byte_tx.sv
// UART byte transmitter, 8N1 LSB first; define UART_TX_PARITY_EN for an even-parity bit after D7.
// Start bit drives the line one clk after accept; send_en is ignored while tx_busy (no queuing).
module uart_byte_tx #(
  parameter int unsigned BIT_CYCLES = 5200
) (
  input  logic           clk,
  input  logic           rst,
  uart_byte_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [15:0] LAST_CNT  = 16'(BIT_CYCLES - 1);
  localparam logic [15:0] STOP_LAST = 16'(BIT_CYCLES - 2);

  state_t      state, state_nxt;
  logic [15:0] bit_cnt, bit_cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shift_reg, shift_reg_nxt;
  logic        uart_tx_q, uart_tx_nxt;
  logic        tx_busy_q, tx_busy_nxt;
  logic        tx_done_q, tx_done_nxt;
  logic        bit_end;
  logic [2:0]  idx_inc;

  assign bit_end = (bit_cnt == LAST_CNT);
  assign idx_inc = bit_idx + 3'd1;

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt + 16'd1;
    bit_idx_nxt   = bit_idx;
    shift_reg_nxt = shift_reg;
    uart_tx_nxt   = uart_tx_q;
    tx_busy_nxt   = tx_busy_q;
    tx_done_nxt   = 1'b0;

    case (state)
      IDLE: begin
        bit_cnt_nxt = '0;
        uart_tx_nxt = 1'b1;
        tx_busy_nxt = 1'b0;
        if (bus.send_en && !tx_busy_q) begin
          shift_reg_nxt = bus.data_byte;
          state_nxt     = START;
          uart_tx_nxt   = 1'b0;
          tx_busy_nxt   = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
          bit_idx_nxt = 3'd0;
          uart_tx_nxt = shift_reg[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          bit_cnt_nxt = '0;
          bit_idx_nxt = idx_inc;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt   = PARITY;
            uart_tx_nxt = ^shift_reg;
`else
            state_nxt   = STOP;
            uart_tx_nxt = 1'b1;
`endif
          end else begin
            uart_tx_nxt = shift_reg[idx_inc];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_nxt   = STOP;
          bit_cnt_nxt = '0;
          uart_tx_nxt = 1'b1;
        end
      end
`endif

      // Leave STOP one cycle early: the following IDLE (tx_done) cycle still holds the line
      // high, so the stop bit lasts BIT_CYCLES and a held send_en restarts with no gap.
      STOP: begin
        if (bit_cnt == STOP_LAST) begin
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
          uart_tx_nxt = 1'b1;
          tx_busy_nxt = 1'b0;
          tx_done_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = '0;
        uart_tx_nxt = 1'b1;
        tx_busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx_q <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift_reg <= shift_reg_nxt;
      uart_tx_q <= uart_tx_nxt;
      tx_busy_q <= tx_busy_nxt;
      tx_done_q <= tx_done_nxt;
    end
  end

  assign bus.uart_tx = uart_tx_q;
  assign bus.tx_busy = tx_busy_q;
  assign bus.tx_done = tx_done_q;

endmodule
